mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1..15: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have ports clk input 1 (sole clock, rising edge) and rst input 1; reset is synchronous and active-high.
REQ-003 SHALL have i_req input 1: instruction-fetch request, held until i_ack.
REQ-004 SHALL have i_addr input 32: instruction byte address.
REQ-005 SHALL have i_ack output 1: one-cycle completion pulse for instruction port.
REQ-006 SHALL have i_rdata output 32: fetched word, valid when i_ack=1.
REQ-007 SHALL have d_req input 1: data request, held until d_ack.
REQ-008 SHALL have d_we input 1: 1=store, 0=load.
REQ-009 SHALL have d_addr input 32: data byte address.
REQ-010 SHALL have d_mask input 2: size code; 1x=word, 01=halfword, 00=byte.
REQ-011 SHALL have d_signed input 1: sign-extend sub-word loads.
REQ-012 SHALL have d_wdata input 32: store data, right-aligned.
REQ-013 SHALL have d_ack output 1: one-cycle completion pulse for data port.
REQ-014 SHALL have d_rdata output 32: load result, valid when d_ack=1.
REQ-015 SHALL have d_err output 1: misaligned-access flag, valid when d_ack=1.
REQ-016 SHALL have ram_we, ram_addr[31:0], ram_mask[1:0], ram_signed, ram_wdata[31:0] outputs and ram_rdata[31:0] input to the shared byte-maskable RAM (combinational read, write on clk edge).
REQ-017 SHALL have busy output 1: high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, one cycle per state.
REQ-019 In IDLE with any request, SHALL pick a winner, latch its addr/mask/signed/wdata/we into registers, and enter ACCESS; with no request, SHALL stay IDLE.
REQ-020 Instruction requests SHALL be latched as mask=2'b10, we=0, signed=0.
REQ-021 Arbitration: data wins over instruction, except when both request and starve counter equals STARVE_LIMIT, then instruction wins.
REQ-022 Starve counter (4-bit) SHALL increment on a data grant while i_req=1, and clear on an instruction grant or on a data grant while i_req=0.
REQ-023 In ACCESS, ram_addr/ram_mask/ram_signed/ram_wdata SHALL be driven from latched registers; outside ACCESS they hold the latched values.
REQ-024 ram_we SHALL equal (state==ACCESS) & latched_we & ~rst & ~misaligned: a single-cycle pulse.
REQ-025 At the end of ACCESS, ram_rdata SHALL be registered into the response register.
REQ-026 In DONE, exactly one of i_ack/d_ack SHALL be 1 (the winner), driven from registered state; i_rdata/d_rdata SHALL present the response register.
REQ-027 Latency: request sampled in IDLE at cycle N -> ack high in cycle N+2; next arbitration at cycle N+3; peak throughput one access per 3 cycles.
REQ-028 Requests arriving in ACCESS/DONE SHALL be ignored until IDLE; the loser's request is not lost while it stays asserted.
REQ-029 A requester holding req after ack SHALL be treated as a new request in the following IDLE.
REQ-030 i_ack and d_ack SHALL never be high simultaneously.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, clear starve counter, latched registers and response register to 0.
REQ-032 Reset values: i_ack=0, d_ack=0, d_err=0, busy=0, ram_we=0, ram_addr=0, ram_mask=0, ram_signed=0, ram_wdata=0, i_rdata=0, d_rdata=0.
REQ-033 rst asserted during ACCESS SHALL suppress the write that cycle and SHALL produce no ack.

Configuration
REQ-034 Macro MEM_ARB_ALIGN_CHECK_EN defined: data access is misaligned when (mask=01 and addr[0]=1) or (mask=1x and addr[1:0]!=0); misaligned SHALL suppress ram_we, return d_rdata=0 and d_err=1 with d_ack.
REQ-035 Macro undefined: d_err SHALL be tied 0 and all accesses SHALL be passed through unchanged.

Verification
REQ-036 Reset then d_req store word 0xDEADBEEF @0x10, then load word @0x10 -> d_ack at N+2 each, load d_rdata=0xDEADBEEF.
REQ-037 Store byte 0x80 @0x13, load byte signed @0x13 -> d_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 i_req and d_req held continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; acks never overlap.
REQ-039 rst pulsed in ACCESS of store 0x12345678 @0x20 -> no ack, later load @0x20 returns prior contents.
REQ-040 With MEM_ARB_ALIGN_CHECK_EN: store word @0x22 -> d_err=1, d_rdata=0, memory unchanged; without macro -> d_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a shared byte-maskable RAM.
// Define MEM_ARB_ALIGN_CHECK_EN to flag and suppress misaligned data accesses.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_mask,
  input  logic        d_signed,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [1:0]  ram_mask,
  output logic        ram_signed,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  mask_q, mask_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        grant_i_q, grant_i_d;
  logic [31:0] resp_q, resp_d;
  logic        misaligned;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  // Instruction fetches are never flagged; only data accesses are checked.
  always_comb begin
    misaligned = 1'b0;
    if (!grant_i_q) begin
      if (mask_q[1]) begin
        misaligned = (addr_q[1:0] != 2'b00);
      end else if (mask_q[0]) begin
        misaligned = addr_q[0];
      end
    end
  end
  assign d_err = d_ack & misaligned;
`else
  assign misaligned = 1'b0;
  assign d_err      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    signed_d  = signed_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    grant_i_d = grant_i_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ACCESS;
          // Data has priority unless the instruction side has waited long enough.
          if (i_req && (!d_req || (starve_q == STARVE_MAX))) begin
            grant_i_d = 1'b1;
            addr_d    = i_addr;
            mask_d    = 2'b10;
            signed_d  = 1'b0;
            wdata_d   = 32'h0;
            we_d      = 1'b0;
            starve_d  = 4'd0;
          end else begin
            grant_i_d = 1'b0;
            addr_d    = d_addr;
            mask_d    = d_mask;
            signed_d  = d_signed;
            wdata_d   = d_wdata;
            we_d      = d_we;
            starve_d  = i_req ? (starve_q + 4'd1) : 4'd0;
          end
        end
      end
      ACCESS: begin
        resp_d  = misaligned ? 32'h0 : ram_rdata;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      addr_q    <= 32'h0;
      mask_q    <= 2'b00;
      signed_q  <= 1'b0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      grant_i_q <= 1'b0;
      resp_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      signed_q  <= signed_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      grant_i_q <= grant_i_d;
      resp_q    <= resp_d;
    end
  end

  // The RAM bus always shows the latched request; only the write strobe is gated.
  assign ram_addr   = addr_q;
  assign ram_mask   = mask_q;
  assign ram_signed = signed_q;
  assign ram_wdata  = wdata_q;
  assign ram_we     = (state_q == ACCESS) & we_q & ~rst & ~misaligned;

  assign i_ack   = (state_q == DONE) & grant_i_q;
  assign d_ack   = (state_q == DONE) & ~grant_i_q;
  assign i_rdata = resp_q;
  assign d_rdata = resp_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then randomized traffic
// against a transaction-level reference model with its own shadow memory.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_mask;
  logic        d_signed;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [1:0]  ram_mask;
  logic        ram_signed;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  logic        mem_clear;
  logic [7:0]  ram [0:255];
  logic [7:0]  shadow [0:255];
  logic [7:0]  wa, ha;

  int checks_total  = 0;
  int checks_passed = 0;

  mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_mask     (d_mask),
    .d_signed   (d_signed),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_mask   (ram_mask),
    .ram_signed (ram_signed),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // RAM read port: word/halfword accesses align down, sub-words are extended.
  always_comb begin
    wa = {ram_addr[7:2], 2'b00};
    ha = {ram_addr[7:1], 1'b0};
    ram_rdata = 32'h0;
    if (ram_mask[1]) begin
      ram_rdata = {ram[wa + 8'd3], ram[wa + 8'd2], ram[wa + 8'd1], ram[wa]};
    end else if (ram_mask[0]) begin
      ram_rdata = {{16{ram_signed & ram[ha + 8'd1][7]}}, ram[ha + 8'd1], ram[ha]};
    end else begin
      ram_rdata = {{24{ram_signed & ram[ram_addr[7:0]][7]}}, ram[ram_addr[7:0]]};
    end
  end

  // RAM write port, plus a bench-only clear so both memories start from zero.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (ram_we) begin
      if (ram_mask[1]) begin
        ram[wa]         <= ram_wdata[7:0];
        ram[wa + 8'd1]  <= ram_wdata[15:8];
        ram[wa + 8'd2]  <= ram_wdata[23:16];
        ram[wa + 8'd3]  <= ram_wdata[31:24];
      end else if (ram_mask[0]) begin
        ram[ha]         <= ram_wdata[7:0];
        ram[ha + 8'd1]  <= ram_wdata[15:8];
      end else begin
        ram[ram_addr[7:0]] <= ram_wdata[7:0];
      end
    end
  end

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_total++;
    if (got === want) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference load: gather n little-endian bytes from the shadow, then extend.
  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] mask,
                                          input logic sgn);
    int n;
    int base;
    longint v;
    n = mask[1] ? 4 : (mask[0] ? 2 : 1);
    base = int'(addr[7:0]) & ~(n - 1);
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(shadow[base + k]) << (8 * k);
    if (sgn && (n < 4) && v[8 * n - 1]) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [1:0] mask, input logic [31:0] wdata);
    int n;
    int base;
    n = mask[1] ? 4 : (mask[0] ? 2 : 1);
    base = int'(addr[7:0]) & ~(n - 1);
    for (int k = 0; k < n; k++) shadow[base + k] = 8'((wdata >> (8 * k)) & 32'hFF);
  endtask

  task automatic doReset(input logic clear_mem);
    @(negedge clk);
    rst = 1'b1; mem_clear = clear_mem; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; mem_clear = 1'b0;
  endtask

  // One data transaction from an idle arbiter; the ack must arrive two cycles later.
  task automatic dataAccess(input logic we, input logic [31:0] addr, input logic [1:0] mask,
                            input logic sgn, input logic [31:0] wdata, input string tag,
                            output logic [31:0] rdata, output logic err);
    int waited;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_mask = mask; d_signed = sgn; d_wdata = wdata;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!d_ack && waited < 10);
    checkOutput({tag, "_latency"}, 32'(waited), 32'd2);
    rdata = d_rdata;
    err   = d_err;
    d_req = 1'b0;
  endtask

  // Random requesters: a side keeps its request stable until acked, then may reissue.
  task automatic applyStimulus(input bit i_done, input bit d_done);
    if (i_done || !i_req) begin
      if ($urandom_range(0, 99) < 50) begin
        i_req  = 1'b1;
        i_addr = {24'h0, 8'($urandom_range(0, 63) * 4)};
      end else begin
        i_req = 1'b0;
      end
    end
    if (d_done || !d_req) begin
      if ($urandom_range(0, 99) < 75) begin
        d_req    = 1'b1;
        d_we     = 1'($urandom_range(0, 1));
        d_mask   = 2'($urandom_range(0, 3));
        d_signed = 1'($urandom_range(0, 1));
        d_wdata  = $urandom();
        d_addr   = {24'h0, 8'($urandom_range(0, 255))};
        if (d_mask[1]) d_addr[1:0] = 2'b00;
        else if (d_mask[0]) d_addr[0] = 1'b0;
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          grants;
    int          waited;
    int          next_arb;
    int          grant_cyc;
    int          ack_cyc;
    int          starve;
    bit          win_i;
    bit          exp_is_load;
    logic [31:0] exp_rdata;

    rst = 1'b1; mem_clear = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_mask = 2'b00; d_signed = 1'b0; d_wdata = 32'h0;

    // Reset values on every output.
    doReset(1'b1);
    checkOutput("rst_i_ack",      32'(i_ack), 32'd0);
    checkOutput("rst_d_ack",      32'(d_ack), 32'd0);
    checkOutput("rst_d_err",      32'(d_err), 32'd0);
    checkOutput("rst_busy",       32'(busy), 32'd0);
    checkOutput("rst_ram_we",     32'(ram_we), 32'd0);
    checkOutput("rst_ram_addr",   ram_addr, 32'd0);
    checkOutput("rst_ram_mask",   32'(ram_mask), 32'd0);
    checkOutput("rst_ram_signed", 32'(ram_signed), 32'd0);
    checkOutput("rst_ram_wdata",  ram_wdata, 32'd0);
    checkOutput("rst_i_rdata",    i_rdata, 32'd0);
    checkOutput("rst_d_rdata",    d_rdata, 32'd0);

    // Word store then load back.
    dataAccess(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, "st_word", rd, er);
    checkOutput("st_word_err", 32'(er), 32'd0);
    dataAccess(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "ld_word", rd, er);
    checkOutput("ld_word_data", rd, 32'hDEADBEEF);

    // Byte store into the top lane, then signed/unsigned byte loads and a word reload.
    dataAccess(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, "st_byte", rd, er);
    dataAccess(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, "ld_byte_s", rd, er);
    checkOutput("ld_byte_s_data", rd, 32'hFFFFFF80);
    dataAccess(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, "ld_byte_u", rd, er);
    checkOutput("ld_byte_u_data", rd, 32'h00000080);
    dataAccess(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, "ld_word2", rd, er);
    checkOutput("ld_word2_data", rd, 32'h80ADBEEF);
    dataAccess(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, "ld_half_s", rd, er);
    checkOutput("ld_half_s_data", rd, 32'hFFFF80AD);

    // Reset landing in ACCESS must kill the write and the ack.
    dataAccess(1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, "st_base", rd, er);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_mask = 2'b10; d_signed = 1'b0;
    d_wdata = 32'h12345678;
    @(negedge clk);
    checkOutput("rstacc_busy", 32'(busy), 32'd1);
    checkOutput("rstacc_we_before", 32'(ram_we), 32'd1);
    rst = 1'b1; d_req = 1'b0;
    #1;
    checkOutput("rstacc_we_gated", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstacc_busy_after", 32'(busy), 32'd0);
    checkOutput("rstacc_ram_addr", ram_addr, 32'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("rstacc_no_ack%0d", c), 32'(d_ack | i_ack), 32'd0);
      @(negedge clk);
    end
    dataAccess(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "rstacc_ld", rd, er);
    checkOutput("rstacc_ld_data", rd, 32'hCAFEF00D);

    // Both sides held: four data grants then one instruction grant, repeating.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_mask = 2'b10; d_signed = 1'b0;
    grants = 0;
    waited = 0;
    while (grants < 10 && waited < 60) begin
      @(negedge clk);
      waited++;
      checkOutput("starve_overlap", 32'(i_ack & d_ack), 32'd0);
      if (i_ack || d_ack) begin
        checkOutput($sformatf("starve_grant%0d_is_i", grants), 32'(i_ack),
                    32'((grants % (STARVE + 1)) == STARVE));
        if (i_ack) checkOutput("starve_i_rdata", i_rdata, 32'h80ADBEEF);
        else       checkOutput("starve_d_rdata", d_rdata, 32'hCAFEF00D);
        grants++;
      end
    end
    checkOutput("starve_grants", 32'(grants), 32'd10);
    i_req = 1'b0; d_req = 1'b0;

    // Misaligned word store at 0x22.
    dataAccess(1'b1, 32'h22, 2'b10, 1'b0, 32'hA5A5A5A5, "mis_st", rd, er);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    checkOutput("mis_err", 32'(er), 32'd1);
    checkOutput("mis_rdata", rd, 32'd0);
    dataAccess(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "mis_ld", rd, er);
    checkOutput("mis_mem_kept", rd, 32'hCAFEF00D);
    dataAccess(1'b1, 32'h21, 2'b01, 1'b0, 32'h0000BEEF, "mis_half", rd, er);
    checkOutput("mis_half_err", 32'(er), 32'd1);
`else
    checkOutput("mis_err", 32'(er), 32'd0);
    dataAccess(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "mis_ld", rd, er);
    checkOutput("mis_mem_written", rd, 32'hA5A5A5A5);
`endif

    // Randomized traffic against the transaction-level model.
    doReset(1'b1);
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    next_arb    = 0;
    grant_cyc   = -10;
    ack_cyc     = -10;
    starve      = 0;
    win_i       = 1'b0;
    exp_is_load = 1'b0;
    exp_rdata   = 32'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      checkOutput("rnd_busy", 32'(busy), 32'((cyc == grant_cyc + 1) || (cyc == grant_cyc + 2)));
      checkOutput("rnd_i_ack", 32'(i_ack), 32'((cyc == ack_cyc) && win_i));
      checkOutput("rnd_d_ack", 32'(d_ack), 32'((cyc == ack_cyc) && !win_i));
      checkOutput("rnd_overlap", 32'(i_ack & d_ack), 32'd0);
      if (cyc == ack_cyc) begin
        if (win_i) begin
          checkOutput("rnd_i_rdata", i_rdata, exp_rdata);
        end else begin
          checkOutput("rnd_d_err", 32'(d_err), 32'd0);
          if (exp_is_load) checkOutput("rnd_d_rdata", d_rdata, exp_rdata);
        end
      end
      applyStimulus((cyc == ack_cyc) && win_i, (cyc == ack_cyc) && !win_i);
      if (cyc >= next_arb && (i_req || d_req)) begin
        win_i = i_req && (!d_req || (starve == STARVE));
        if (win_i) starve = 0;
        else starve = i_req ? (starve + 1) : 0;
        grant_cyc = cyc;
        ack_cyc   = cyc + 2;
        next_arb  = cyc + 3;
        if (win_i) begin
          exp_is_load = 1'b1;
          exp_rdata   = refLoad(i_addr, 2'b10, 1'b0);
        end else begin
          exp_is_load = !d_we;
          if (!d_we) exp_rdata = refLoad(d_addr, d_mask, d_signed);
          else       refStore(d_addr, d_mask, d_wdata);
        end
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
